fu_wb_arbiter: RTL and testbench
================================

// Module: fu_wb_arbiter
// PURPOSE
//  Write-back collector downstream of the functional units (ALU, JUMP, MEM, MUL, DIV).
//  FUs raise a one-cycle finish pulse and do not hold res afterwards.
//  This block captures each result into a per-FU holding slot.
//  It then drives one registered write-back per cycle to the regfile/scoreboard, chosen round-robin.
// PARAMETERS
//  N_FU    5   number of FU result sources (index = FU id)
//  DW      32  result width
//  RW      5   destination register address width
// PORTS
//  clk         in   1        clock; all state updates on posedge
//  rst_n       in   1        synchronous reset, active-low
//  fu_finish   in   N_FU     per-FU one-cycle result-valid pulse
//  fu_res      in   N_FU*DW  per-FU result; slice i = [i*DW +: DW]
//  fu_rd       in   N_FU*RW  per-FU dest reg, sampled with fu_finish
//  fu_busy     out  N_FU     slot i holds an unretired result; issue must not start FU i
//  wb_valid    out  1        write-back beat valid this cycle
//  wb_we       out  1        wb_valid & (wb_rd != 0)
//  wb_rd       out  RW       write-back destination
//  wb_data     out  DW       write-back data
//  wb_fu       out  3        id of the FU being retired
//  ovf_err     out  1        sticky: finish arrived on a full slot
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all slots invalid; wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, wb_fu=0,
//   fu_busy=0, ovf_err=0, RR pointer=0. Reset mid-operation discards all pending results.
//  Capture: at posedge, if fu_finish[i], slot i <= {1, fu_res[i], fu_rd[i]}.
//  Arbitration (combinational on slot valids): grant the lowest valid index >= ptr, wrapping to 0.
//  Retire at posedge: wb_* <= granted slot; granted slot cleared; ptr <= grant+1 (mod N_FU).
//   No valid slot: wb_valid<=0 and wb_we<=0; wb_rd/wb_data/wb_fu hold their previous values.
//  Latency: finish at edge t -> wb_valid high in cycle after edge t+1 (min 1 cycle in slot).
//   Throughput: one write-back per cycle total.
//  Fairness: a pending slot retires within N_FU cycles.
//  fu_busy[i] = slot_valid[i] (registered state, no comb path from fu_finish).
//  Simultaneous retire+finish on the same slot: old content retires; new content is captured.
//   Slot stays valid; no overflow.
//  Finish on a valid slot that is not granted that cycle: new result dropped, old kept,
//   ovf_err <= 1 until reset.
//  wb_we uses the registered rd: rd==0 gives wb_valid=1, wb_we=0 (x0 never written).
//  ptr only advances on a grant.
// STRUCTURE
//  Shared header fu_defs.vh: FU id localparams (FU_ALU=0, FU_JUMP=1, FU_MEM=2, FU_MUL=3, FU_DIV=4),
//   N_FU, DW, RW.
//  Sub-module rr_arbiter #(N) (req[N], ptr -> one-hot gnt, gnt_idx, any).
//   Pure combinational; reused by the issue stage.
//  Top level holds the slot registers, the ptr register and the output registers.
// TESTING
//  1 Reset: drive rst_n=0 with fu_finish=5'b11111 -> after release all outputs 0, fu_busy=0.
//  2 Single: DIV finish, res=32'h0000_0007, rd=5 -> next cycle wb_valid=1, wb_rd=5, wb_data=7,
//    wb_fu=4; fu_busy[4] drops on the same edge.
//  3 All five finish the same cycle, ptr=0 -> wb_fu sequence 0,1,2,3,4 over 5 consecutive cycles.
//    ptr then =0 (wraps).
//  4 Overflow: MUL finishes twice while ALU/JUMP/MEM are kept pending ahead of it
//    (res 32'hA then 32'hB) -> 32'hA retired, ovf_err=1 stays set.
//  5 Same-cycle retire+finish on DIV: res 32'h1 in slot; 32'h2 arrives as the slot is granted
//    -> beats 1 then 2, ovf_err=0.
//  6 rd=0 from ALU, res 32'hFFFF_FFFF -> wb_valid=1, wb_we=0.
//    Assert rst_n=0 with 3 slots pending -> no further wb_valid.

Source files
------------

// File: rtl/fu_wb_arbiter_pkg.sv
// Shared definitions for the FU write-back collector: FU ids, widths and the slot record.
package fu_wb_arbiter_pkg;
    localparam int N_FU = 5;
    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int FUW  = 3;
    localparam int PW   = $clog2(N_FU);

    localparam logic [FUW-1:0] FU_ALU  = 3'd0;
    localparam logic [FUW-1:0] FU_JUMP = 3'd1;
    localparam logic [FUW-1:0] FU_MEM  = 3'd2;
    localparam logic [FUW-1:0] FU_MUL  = 3'd3;
    localparam logic [FUW-1:0] FU_DIV  = 3'd4;

    typedef struct packed {
        logic          vld;
        logic [DW-1:0] res;
        logic [RW-1:0] rd;
    } slot_t;
endpackage

// File: rtl/fu_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);
    always_comb begin
        int j;
        j       = 0;
        any     = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any     = 1'b1;
                gnt_idx = PW'(j);
            end
        end
        if (any) gnt[gnt_idx] = 1'b1;
    end
endmodule

// File: rtl/fu_wb_arbiter.sv
// Captures one-cycle FU result pulses into per-FU slots and retires one slot per cycle
// round-robin onto a registered write-back port.
module fu_wb_arbiter
    import fu_wb_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_FU-1:0]    fu_finish,
    input  logic [N_FU*DW-1:0] fu_res,
    input  logic [N_FU*RW-1:0] fu_rd,
    output logic [N_FU-1:0]    fu_busy,
    output logic               wb_valid,
    output logic               wb_we,
    output logic [RW-1:0]      wb_rd,
    output logic [DW-1:0]      wb_data,
    output logic [FUW-1:0]     wb_fu,
    output logic               ovf_err
);
    slot_t           slot_q [N_FU];
    slot_t           slot_d [N_FU];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q, wb_we_d;
    logic [RW-1:0]   wb_rd_q, wb_rd_d;
    logic [DW-1:0]   wb_data_q, wb_data_d;
    logic [FUW-1:0]  wb_fu_q, wb_fu_d;
    logic            ovf_q, ovf_d;

    logic [N_FU-1:0] slot_vld;
    logic [N_FU-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            any;

    always_comb begin
        for (int i = 0; i < N_FU; i++) slot_vld[i] = slot_q[i].vld;
    end

    rr_arbiter #(.N(N_FU), .PW(PW)) u_rr (
        .req     (slot_vld),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        slot_d     = slot_q;
        ptr_d      = ptr_q;
        ovf_d      = ovf_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_fu_d    = wb_fu_q;
        if (any) begin
            wb_valid_d            = 1'b1;
            wb_rd_d               = slot_q[gnt_idx].rd;
            wb_we_d               = (slot_q[gnt_idx].rd != '0);
            wb_data_d             = slot_q[gnt_idx].res;
            wb_fu_d               = FUW'(gnt_idx);
            slot_d[gnt_idx].vld   = 1'b0;
            ptr_d                 = (gnt_idx == PW'(N_FU - 1)) ? '0 : gnt_idx + PW'(1);
        end
        // A slot being retired this edge frees up in time to accept a new result.
        for (int i = 0; i < N_FU; i++) begin
            if (fu_finish[i]) begin
                if (!slot_q[i].vld || gnt[i])
                    slot_d[i] = {1'b1, fu_res[i*DW +: DW], fu_rd[i*RW +: RW]};
                else
                    ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_FU; i++) slot_q[i] <= '0;
            ptr_q      <= '0;
            ovf_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_fu_q    <= '0;
        end else begin
            slot_q     <= slot_d;
            ptr_q      <= ptr_d;
            ovf_q      <= ovf_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_fu_q    <= wb_fu_d;
        end
    end

    assign fu_busy  = slot_vld;
    assign wb_valid = wb_valid_q;
    assign wb_we    = wb_we_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_fu    = wb_fu_q;
    assign ovf_err  = ovf_q;
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Scoreboard bench for fu_wb_arbiter: expected beats are queued as results are injected.
module tb_fu_wb_arbiter;
    import fu_wb_arbiter_pkg::*;

    typedef struct {
        logic [RW-1:0]  rd;
        logic [DW-1:0]  data;
        logic [FUW-1:0] fu;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_FU-1:0]    fu_finish;
    logic [N_FU*DW-1:0] fu_res;
    logic [N_FU*RW-1:0] fu_rd;
    logic [N_FU-1:0]    fu_busy;
    logic               wb_valid, wb_we, ovf_err;
    logic [RW-1:0]      wb_rd;
    logic [DW-1:0]      wb_data;
    logic [FUW-1:0]     wb_fu;

    int    errors = 0;
    int    checks = 0;
    beat_t sb[$];

    always #5 clk = ~clk;

    fu_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .fu_finish(fu_finish), .fu_res(fu_res), .fu_rd(fu_rd),
        .fu_busy(fu_busy), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_fu(wb_fu), .ovf_err(ovf_err)
    );

    // Monitor: every beat must match the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n === 1'b1) begin
            checks++;
            if (wb_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got fu=%0d rd=%0d data=%h, expected no beat",
                             wb_fu, wb_rd, wb_data);
                end else begin
                    e = sb.pop_front();
                    if (wb_fu !== e.fu || wb_rd !== e.rd || wb_data !== e.data ||
                        wb_we !== (e.rd != '0)) begin
                        errors++;
                        $display("FAIL beat: got fu=%0d rd=%0d data=%h we=%b, expected fu=%0d rd=%0d data=%h we=%b",
                                 wb_fu, wb_rd, wb_data, wb_we, e.fu, e.rd, e.data, (e.rd != '0));
                    end
                end
            end else if (wb_we !== 1'b0) begin
                errors++;
                $display("FAIL we_idle: got wb_we=%b with wb_valid=%b, expected 0", wb_we, wb_valid);
            end
        end
    end

    task automatic set_fu(input int i, input logic [DW-1:0] r, input logic [RW-1:0] d);
        fu_finish[i]       = 1'b1;
        fu_res[i*DW +: DW] = r;
        fu_rd[i*RW +: RW]  = d;
    endtask

    task automatic step();
        @(posedge clk); #1;
        fu_finish = '0;
    endtask

    task automatic expect_beat(input int fu, input logic [RW-1:0] rd, input logic [DW-1:0] data);
        beat_t b;
        b.fu = FUW'(fu); b.rd = rd; b.data = data;
        sb.push_back(b);
    endtask

    task automatic drain(input string name);
        repeat (12) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats still outstanding, expected 0", name, sb.size());
        end
        sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        fu_finish = '1;
        fu_res = {N_FU{32'hDEAD_BEEF}};
        fu_rd  = {N_FU{5'd9}};
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fu_finish = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rd !== '0 || wb_data !== '0 ||
            wb_fu !== '0 || fu_busy !== '0 || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: got valid=%b we=%b rd=%0d data=%h fu=%0d busy=%b ovf=%b, expected all 0",
                     wb_valid, wb_we, wb_rd, wb_data, wb_fu, fu_busy, ovf_err);
        end
        drain("reset");
    endtask

    task automatic test_single();
        expect_beat(4, 5'd5, 32'h0000_0007);
        set_fu(4, 32'h0000_0007, 5'd5);
        step();
        @(negedge clk);
        checks++;
        if (fu_busy !== 5'b10000 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_slot: got busy=%b valid=%b, expected busy=10000 valid=0", fu_busy, wb_valid);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || fu_busy !== 5'b00000) begin
            errors++;
            $display("FAIL single_retire: got valid=%b busy=%b, expected valid=1 busy=00000", wb_valid, fu_busy);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 32'h7 || wb_fu !== 3'd4) begin
            errors++;
            $display("FAIL single_hold: got valid=%b rd=%0d data=%h fu=%0d, expected valid=0 rd=5 data=7 fu=4",
                     wb_valid, wb_rd, wb_data, wb_fu);
        end
        drain("single");
    endtask

    task automatic test_all_five();
        int n;
        n = 0;
        for (int i = 0; i < N_FU; i++) begin
            expect_beat(i, RW'(i + 1), 32'h100 + DW'(i));
            set_fu(i, 32'h100 + DW'(i), RW'(i + 1));
        end
        step();
        @(negedge clk);
        for (int c = 0; c < N_FU; c++) begin
            @(negedge clk);
            if (wb_valid === 1'b1) n++;
        end
        checks++;
        if (n != N_FU) begin
            errors++;
            $display("FAIL all_five_consecutive: got %0d beats in 5 cycles, expected 5", n);
        end
        // Pointer must have wrapped to 0: FU0 beats FU4.
        @(posedge clk); #1;
        expect_beat(0, 5'd11, 32'hA0);
        expect_beat(4, 5'd12, 32'hA4);
        set_fu(0, 32'hA0, 5'd11);
        set_fu(4, 32'hA4, 5'd12);
        step();
        drain("all_five");
    endtask

    task automatic test_overflow();
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pre: got ovf_err=%b, expected 0", ovf_err);
        end
        expect_beat(0, 5'd1, 32'h10);
        expect_beat(1, 5'd2, 32'h11);
        expect_beat(2, 5'd3, 32'h12);
        expect_beat(3, 5'd6, 32'hA);
        set_fu(0, 32'h10, 5'd1);
        set_fu(1, 32'h11, 5'd2);
        set_fu(2, 32'h12, 5'd3);
        set_fu(3, 32'hA, 5'd6);
        step();
        set_fu(3, 32'hB, 5'd9);
        step();
        @(negedge clk);
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got ovf_err=%b, expected 1", ovf_err);
        end
        drain("overflow");
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf_err=%b, expected 1", ovf_err);
        end
    endtask

    task automatic test_back_to_back();
        expect_beat(4, 5'd7, 32'h1);
        expect_beat(4, 5'd7, 32'h2);
        set_fu(4, 32'h1, 5'd7);
        step();
        set_fu(4, 32'h2, 5'd7);
        step();
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || fu_busy !== 5'b10000) begin
            errors++;
            $display("FAIL b2b_first: got valid=%b busy=%b, expected valid=1 busy=10000", wb_valid, fu_busy);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got valid=%b, expected 1", wb_valid);
        end
        drain("b2b");
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ovf: got ovf_err=%b, expected 0", ovf_err);
        end
    endtask

    task automatic test_rd0_and_reset();
        int n;
        n = 0;
        expect_beat(0, 5'd0, 32'hFFFF_FFFF);
        set_fu(0, 32'hFFFF_FFFF, 5'd0);
        step();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin
            errors++;
            $display("FAIL rd0: got valid=%b we=%b, expected valid=1 we=0", wb_valid, wb_we);
        end
        drain("rd0");
        set_fu(1, 32'h21, 5'd1);
        set_fu(2, 32'h22, 5'd2);
        set_fu(3, 32'h23, 5'd3);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (fu_busy !== 5'b01110) begin
            errors++;
            $display("FAIL mid_pending: got busy=%b, expected 01110", fu_busy);
        end
        repeat (2) begin
            @(negedge clk);
            if (wb_valid !== 1'b0) n++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (wb_valid !== 1'b0) n++;
        end
        checks++;
        if (n != 0 || fu_busy !== '0) begin
            errors++;
            $display("FAIL mid_reset: got %0d beats busy=%b, expected 0 beats busy=00000", n, fu_busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        fu_finish = '0;
        fu_res = '0;
        fu_rd = '0;
        test_reset();
        test_single();
        test_all_five();
        test_overflow();
        apply_reset();
        test_back_to_back();
        test_rd0_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
